lcd_avalon_ctrl: RTL and testbench
==================================

LCD_AVALON_CTRL -- requirements
Module: lcd_avalon_ctrl

Interface
REQ-001 SHALL provide parameter POWERUP_CYC, default 750000, meaning cycles to wait after reset before init (15 ms at 50 MHz).
REQ-002 SHALL provide parameter SETUP_CYC, default 4, meaning RS/RW/DATA setup cycles before EN rises.
REQ-003 SHALL provide parameter EN_CYC, default 16, meaning EN high width in cycles.
REQ-004 SHALL provide parameter HOLD_CYC, default 4, meaning DATA/RS hold cycles after EN falls.
REQ-005 SHALL provide parameter EXEC_CYC, default 2000, meaning execution wait for normal instructions and data writes.
REQ-006 SHALL provide parameter LONG_EXEC_CYC, default 82000, meaning execution wait for clear/home instructions.
REQ-007 SHALL have ports (name, direction, width, meaning):
- clk  in  1  single clock.
- reset  in  1  synchronous, active-high.
- address  in  1  0 = instruction (RS=0), 1 = data (RS=1).
- chipselect  in  1  slave select.
- byteenable  in  1  byte lane enable.
- read  in  1  read request.
- write  in  1  write request.
- writedata  in  8  LCD byte.
- waitrequest  out  1  stall.
- readdata  out  8  always 0.
- response  out  2  always 2'b00 (OKAY).
- LCD_DATA  out  8  panel data bus.
- LCD_RW  out  1  tied 0, write only.
- LCD_EN  out  1  panel enable strobe.
- LCD_RS  out  1  register select.
- LCD_ON  out  1  panel power.
- LCD_BLON  out  1  backlight.

Function
REQ-008 SHALL implement states PWR_WAIT, INIT, IDLE, SETUP, PULSE, HOLD, EXEC, using one down-counter of at least 20 bits.
REQ-009 SHALL enter PWR_WAIT on reset, count POWERUP_CYC cycles, then go to INIT.
REQ-010 SHALL, in INIT, issue the instruction sequence 0x38, 0x0C, 0x06, 0x01 (RS=0) in that order, each through SETUP->PULSE->HOLD->EXEC, then enter IDLE.
REQ-011 SHALL drive waitrequest=0 only in IDLE; waitrequest=1 in every other state, including all of PWR_WAIT and INIT.
REQ-012 SHALL accept a transfer on any IDLE cycle with chipselect=1 and (write=1 or read=1); acceptance completes the Avalon transfer in that cycle (zero wait states when idle).
REQ-013 SHALL, on accepted write with byteenable=1, latch writedata into LCD_DATA and address into LCD_RS, then go to SETUP on the next cycle.
REQ-014 SHALL make SETUP last SETUP_CYC, PULSE EN_CYC (LCD_EN=1 only in PULSE), HOLD HOLD_CYC, and EXEC the selected execution wait, then return to IDLE.
REQ-015 SHALL select LONG_EXEC_CYC when RS=0 and writedata[7:2]==0 with writedata!=0 (0x01, 0x02, 0x03); otherwise EXEC_CYC.
REQ-016 SHALL, on an accepted write with byteenable=0, or on an accepted read, complete the transfer, issue no LCD cycle, and remain in IDLE.
REQ-017 SHALL treat read=1 and write=1 in the same cycle as a write.
REQ-018 SHALL ignore write/read while chipselect=0, in any state.
REQ-019 SHALL hold LCD_DATA and LCD_RS stable from SETUP through HOLD; their values are don't-care in IDLE/EXEC but not changed until the next acceptance.
REQ-020 SHALL keep a write presented while busy stalled; the master holds it, and it is accepted on the first IDLE cycle. No queueing beyond one transfer.
REQ-021 SHALL drive LCD_ON=1, LCD_BLON=1, LCD_RW=0, readdata=0, response=0 at all times after reset.
REQ-022 SHALL make the total busy time per write SETUP_CYC+EN_CYC+HOLD_CYC+exec+1 cycles, counted from the acceptance cycle to the next waitrequest=0.

Reset
REQ-023 SHALL, on reset=1 at a clock edge, set state=PWR_WAIT, LCD_EN=0, LCD_DATA=0, LCD_RS=0, waitrequest=1, and reload the counter with POWERUP_CYC.
REQ-024 SHALL abort any in-progress SETUP/PULSE/HOLD/EXEC or INIT on reset, with LCD_EN low on the cycle after reset is sampled, and rerun the full init sequence.

Verification (sim parameters POWERUP_CYC=100, SETUP_CYC=2, EN_CYC=4, HOLD_CYC=2, EXEC_CYC=20, LONG_EXEC_CYC=50)
REQ-025 SHALL cover power-up: reset then idle bus -> waitrequest=1 for 100 cycles, four EN pulses carrying 0x38, 0x0C, 0x06, 0x01 with RS=0, then waitrequest=0.
REQ-026 SHALL cover a data write: address=1, writedata=0x48 accepted in IDLE -> LCD_RS=1, LCD_DATA=0x48, EN high exactly 4 cycles, waitrequest low again 29 cycles after acceptance.
REQ-027 SHALL cover a clear: address=0, writedata=0x01 -> long wait, waitrequest low again 59 cycles after acceptance; a second write held during that time is accepted only then.
REQ-028 SHALL cover the no-op paths: read=1 in IDLE -> accepted the same cycle, readdata=0, no EN pulse; write with byteenable=0 -> accepted, no EN pulse.
REQ-029 SHALL cover reset mid-PULSE: reset asserted while EN=1 -> EN=0 on the next cycle, waitrequest=1, full 100-cycle wait plus init replayed.
REQ-030 SHALL cover a 17-write burst (0x01 then 16 characters) driven by a master that holds write until waitrequest=0 -> exactly 17 EN pulses in order, none dropped or duplicated.

Source files
------------

// File: rtl/lcd_avalon_ctrl.sv
// lcd_avalon_ctrl: Avalon-MM slave that turns single-byte writes into
// HD44780-style LCD bus cycles (setup, enable pulse, hold, execution wait).
// After reset it waits for panel power-up and plays a fixed init sequence
// before it starts accepting transfers.
module lcd_avalon_ctrl #(
    parameter int unsigned POWERUP_CYC   = 750000,
    parameter int unsigned SETUP_CYC     = 4,
    parameter int unsigned EN_CYC        = 16,
    parameter int unsigned HOLD_CYC      = 4,
    parameter int unsigned EXEC_CYC      = 2000,
    parameter int unsigned LONG_EXEC_CYC = 82000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       address,
    input  logic       chipselect,
    input  logic       byteenable,
    input  logic       read,
    input  logic       write,
    input  logic [7:0] writedata,
    output logic       waitrequest,
    output logic [7:0] readdata,
    output logic [1:0] response,
    output logic [7:0] LCD_DATA,
    output logic       LCD_RW,
    output logic       LCD_EN,
    output logic       LCD_RS,
    output logic       LCD_ON,
    output logic       LCD_BLON
);

    // The counter is sized for the longest wait, never narrower than 20 bits.
    localparam int unsigned MAX_A = (POWERUP_CYC > LONG_EXEC_CYC) ? POWERUP_CYC : LONG_EXEC_CYC;
    localparam int unsigned MAX_B = (MAX_A > EXEC_CYC) ? MAX_A : EXEC_CYC;
    localparam int          CNT_W = ($clog2(MAX_B + 1) > 20) ? $clog2(MAX_B + 1) : 20;

    typedef enum logic [2:0] {
        PWR_WAIT = 3'd0,
        INIT     = 3'd1,
        IDLE     = 3'd2,
        SETUP    = 3'd3,
        PULSE    = 3'd4,
        HOLD     = 3'd5,
        EXEC     = 3'd6
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_lcd_en;
    logic [7:0]       r_lcd_data;
    logic             r_lcd_rs;
    logic             r_waitrequest;
    logic [1:0]       r_init_idx;
    logic             r_init_active;

    logic             w_accept;
    logic             w_start;
    logic             w_cnt_last;
    logic [CNT_W-1:0] w_cnt_dec;
    logic             w_long;

    // Power-on instruction table: 8-bit 2-line, display on, entry inc, clear.
    function automatic logic [7:0] init_byte(input logic [1:0] idx);
        case (idx)
            2'd0:    init_byte = 8'h38;
            2'd1:    init_byte = 8'h0C;
            2'd2:    init_byte = 8'h06;
            default: init_byte = 8'h01;
        endcase
    endfunction

    // A transfer completes on any idle cycle; only a byte-enabled write starts a bus cycle.
    assign w_accept   = (r_state == IDLE) && chipselect && (write || read);
    assign w_start    = w_accept && write && byteenable;
    // Every timed state counts its length down to 1, then moves on.
    assign w_cnt_last = (r_cnt <= CNT_W'(1));
    assign w_cnt_dec  = r_cnt - CNT_W'(1);
    // Clear (0x01) and home (0x02/0x03) instructions need the long wait.
    assign w_long     = !r_lcd_rs && (r_lcd_data[7:2] == 6'd0) && (r_lcd_data != 8'h00);

    // Main sequencer: state, shared down-counter and all registered panel outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= PWR_WAIT;
            r_cnt         <= CNT_W'(POWERUP_CYC);
            r_lcd_en      <= 1'b0;
            r_lcd_data    <= 8'h00;
            r_lcd_rs      <= 1'b0;
            r_waitrequest <= 1'b1;
            r_init_idx    <= 2'd0;
            r_init_active <= 1'b1;
        end else begin
            case (r_state)
                PWR_WAIT: begin
                    if (w_cnt_last) begin
                        r_state    <= INIT;
                        r_init_idx <= 2'd0;
                    end else begin
                        r_cnt <= w_cnt_dec;
                    end
                end
                INIT: begin
                    r_lcd_data <= init_byte(r_init_idx);
                    r_lcd_rs   <= 1'b0;
                    r_cnt      <= CNT_W'(SETUP_CYC);
                    r_state    <= SETUP;
                end
                IDLE: begin
                    if (w_start) begin
                        r_lcd_data    <= writedata;
                        r_lcd_rs      <= address;
                        r_cnt         <= CNT_W'(SETUP_CYC);
                        r_waitrequest <= 1'b1;
                        r_state       <= SETUP;
                    end else begin
                        r_waitrequest <= 1'b0;
                    end
                end
                SETUP: begin
                    if (w_cnt_last) begin
                        r_lcd_en <= 1'b1;
                        r_cnt    <= CNT_W'(EN_CYC);
                        r_state  <= PULSE;
                    end else begin
                        r_cnt <= w_cnt_dec;
                    end
                end
                PULSE: begin
                    if (w_cnt_last) begin
                        r_lcd_en <= 1'b0;
                        r_cnt    <= CNT_W'(HOLD_CYC);
                        r_state  <= HOLD;
                    end else begin
                        r_cnt <= w_cnt_dec;
                    end
                end
                HOLD: begin
                    if (w_cnt_last) begin
                        r_cnt   <= w_long ? CNT_W'(LONG_EXEC_CYC) : CNT_W'(EXEC_CYC);
                        r_state <= EXEC;
                    end else begin
                        r_cnt <= w_cnt_dec;
                    end
                end
                EXEC: begin
                    if (w_cnt_last) begin
                        if (r_init_active && (r_init_idx != 2'd3)) begin
                            r_init_idx <= r_init_idx + 2'd1;
                            r_state    <= INIT;
                        end else begin
                            r_init_active <= 1'b0;
                            r_waitrequest <= 1'b0;
                            r_state       <= IDLE;
                        end
                    end else begin
                        r_cnt <= w_cnt_dec;
                    end
                end
                default: begin
                    r_state       <= PWR_WAIT;
                    r_cnt         <= CNT_W'(POWERUP_CYC);
                    r_lcd_en      <= 1'b0;
                    r_waitrequest <= 1'b1;
                    r_init_idx    <= 2'd0;
                    r_init_active <= 1'b1;
                end
            endcase
        end
    end

    assign waitrequest = r_waitrequest;
    assign LCD_EN      = r_lcd_en;
    assign LCD_DATA    = r_lcd_data;
    assign LCD_RS      = r_lcd_rs;
    // Write-only panel, always powered with backlight on; reads return zero, OKAY.
    assign LCD_RW      = 1'b0;
    assign LCD_ON      = 1'b1;
    assign LCD_BLON    = 1'b1;
    assign readdata    = 8'h00;
    assign response    = 2'b00;

endmodule

// File: tb/tb_lcd_avalon_ctrl.sv
// Bench for lcd_avalon_ctrl: directed scenarios plus random Avalon traffic,
// checked every cycle against a transfer-level timing model.
module tb_lcd_avalon_ctrl;

    localparam int P_PWR   = 100;
    localparam int P_SETUP = 2;
    localparam int P_EN    = 4;
    localparam int P_HOLD  = 2;
    localparam int P_EXEC  = 20;
    localparam int P_LONG  = 50;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       address = 1'b0;
    logic       chipselect = 1'b0;
    logic       byteenable = 1'b0;
    logic       read = 1'b0;
    logic       write = 1'b0;
    logic [7:0] writedata = 8'h00;
    logic       waitrequest;
    logic [7:0] readdata;
    logic [1:0] response;
    logic [7:0] LCD_DATA;
    logic       LCD_RW;
    logic       LCD_EN;
    logic       LCD_RS;
    logic       LCD_ON;
    logic       LCD_BLON;

    int vectors = 0;
    int miscompares = 0;
    int en_rises = 0;

    lcd_avalon_ctrl #(
        .POWERUP_CYC(P_PWR), .SETUP_CYC(P_SETUP), .EN_CYC(P_EN),
        .HOLD_CYC(P_HOLD), .EXEC_CYC(P_EXEC), .LONG_EXEC_CYC(P_LONG)
    ) dut (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .byteenable(byteenable), .read(read), .write(write), .writedata(writedata),
        .waitrequest(waitrequest), .readdata(readdata), .response(response),
        .LCD_DATA(LCD_DATA), .LCD_RW(LCD_RW), .LCD_EN(LCD_EN), .LCD_RS(LCD_RS),
        .LCD_ON(LCD_ON), .LCD_BLON(LCD_BLON)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Clear and home instructions take the long execution time.
    function automatic bit is_long(input logic a, input logic [7:0] d);
        return !a && (d == 8'h01 || d == 8'h02 || d == 8'h03);
    endfunction

    // ---------------- reference model + per-cycle compare ----------------
    logic [7:0] init_tab [4] = '{8'h38, 8'h0C, 8'h06, 8'h01};
    int   mode, pwr, init_cyc, init_n, pw, cyc, acc, tot, k;
    bit   prev_rst, en_prev, en_last, busy, exp_wr, exp_en;
    logic [7:0] last_data;
    logic last_rs;

    always @(negedge clk) begin
        cyc++;
        if (reset) begin
            mode = 0; pwr = 0; init_cyc = 0; init_n = 0; pw = 0;
            en_prev = 1'b0; busy = 1'b0; prev_rst = 1'b1;
        end else begin
            chk("const_outputs", {readdata, response, LCD_RW, LCD_ON, LCD_BLON},
                {8'h00, 2'b00, 1'b0, 1'b1, 1'b1});
            if (LCD_EN && !en_last) en_rises++;
            if (prev_rst) begin
                chk("reset_en", LCD_EN, 1'b0);
                chk("reset_waitreq", waitrequest, 1'b1);
                chk("reset_data_rs", {LCD_RS, LCD_DATA}, 9'h000);
                prev_rst = 1'b0;
            end
            if (mode == 0) begin
                if (pwr < P_PWR) begin
                    chk("pwr_wait_waitreq", waitrequest, 1'b1);
                    chk("pwr_wait_en", LCD_EN, 1'b0);
                    pwr++;
                end else begin
                    init_cyc++;
                    if (LCD_EN && !en_prev) begin
                        if (init_n >= 4) chk("init_extra_pulse", init_n, 3);
                        init_n++;
                        pw = 0;
                    end
                    if (LCD_EN) begin
                        pw++;
                        if (init_n >= 1 && init_n <= 4)
                            chk("init_byte", {LCD_RS, LCD_DATA}, {1'b0, init_tab[init_n-1]});
                    end
                    if (!LCD_EN && en_prev) chk("init_en_width", pw, P_EN);
                    if (!waitrequest) begin
                        chk("init_pulse_count", init_n, 4);
                        mode = 1; busy = 1'b0; last_data = 8'h01; last_rs = 1'b0;
                    end else if (init_cyc > 1000) begin
                        chk("init_timeout", 0, 1);
                        mode = 2;
                    end
                end
                en_prev = LCD_EN;
            end
            if (mode == 1) begin
                if (busy && (cyc - acc) >= tot) busy = 1'b0;
                if (busy) begin
                    k = cyc - acc;
                    exp_wr = 1'b1;
                    exp_en = (k > P_SETUP) && (k <= P_SETUP + P_EN);
                end else begin
                    exp_wr = 1'b0;
                    exp_en = 1'b0;
                end
                chk("waitrequest", waitrequest, exp_wr);
                chk("lcd_en", LCD_EN, exp_en);
                chk("lcd_data_rs", {LCD_RS, LCD_DATA}, {last_rs, last_data});
                if (!busy && chipselect && (write || read) && write && byteenable) begin
                    busy = 1'b1;
                    acc = cyc;
                    last_data = writedata;
                    last_rs = address;
                    tot = P_SETUP + P_EN + P_HOLD + (is_long(address, writedata) ? P_LONG : P_EXEC) + 1;
                end
            end
        end
        en_last = LCD_EN;
    end

    // ---------------- master-side helpers ----------------
    task automatic xfer(input bit cs, input bit w, input bit r, input bit be, input bit a,
                        input logic [7:0] d, input bit measure, output int wt, output int lat);
        int n;
        bit ok;
        @(posedge clk); #1;
        chipselect = cs; write = w; read = r; byteenable = be; address = a; writedata = d;
        wt = -1; lat = -1;
        if (cs && (w || r)) begin
            n = 0; ok = 1'b0;
            while (!ok && n < 2000) begin
                @(negedge clk); n++;
                if (!waitrequest) ok = 1'b1;
            end
            wt = n;
            chk("accept_timeout", ok, 1'b1);
            if (measure) begin
                @(posedge clk); #1;
                chipselect = 1'b0; write = 1'b0; read = 1'b0;
                n = 0; ok = 1'b0;
                while (!ok && n < 2000) begin
                    @(negedge clk); n++;
                    if (!waitrequest) ok = 1'b1;
                end
                lat = n;
            end
        end else begin
            repeat ($urandom_range(1, 3)) @(negedge clk);
        end
    endtask

    task automatic idle_bus();
        @(posedge clk); #1;
        chipselect = 1'b0; write = 1'b0; read = 1'b0;
    endtask

    task automatic wait_idle(output int n);
        bit ok;
        n = 0; ok = 1'b0;
        while (!ok && n < 3000) begin
            @(negedge clk); n++;
            if (!waitrequest) ok = 1'b1;
        end
        chk("idle_timeout", ok, 1'b1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int wt, lat, n, r0, sel, op;
        bit cs, w, r, be, a;
        logic [7:0] d;

        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        wait_idle(n);
        chk("powerup_wait_len", n > P_PWR, 1'b1);

        // data write 'H'
        r0 = en_rises;
        xfer(1, 1, 0, 1, 1, 8'h48, 1, wt, lat);
        chk("data_accept_wait", wt, 1);
        chk("data_busy_cycles", lat, 29);
        chk("data_pulse_count", en_rises - r0, 1);

        // clear with a write held behind it
        xfer(1, 1, 0, 1, 0, 8'h01, 0, wt, lat);
        xfer(1, 1, 0, 1, 1, 8'h41, 1, wt, lat);
        chk("held_accept_wait", wt, 59);
        chk("held_busy_cycles", lat, 29);

        // read: zero-wait no-op
        r0 = en_rises;
        xfer(1, 0, 1, 1, 0, 8'h00, 1, wt, lat);
        chk("read_accept_wait", wt, 1);
        chk("read_busy_cycles", lat, 1);
        // write with byteenable=0: no-op
        xfer(1, 1, 0, 0, 1, 8'h5A, 1, wt, lat);
        chk("be0_accept_wait", wt, 1);
        chk("be0_busy_cycles", lat, 1);
        // chipselect low: ignored
        xfer(0, 1, 0, 1, 1, 8'h77, 0, wt, lat);
        idle_bus();
        repeat (10) @(negedge clk);
        chk("noop_no_pulse", en_rises - r0, 0);

        // read+write together behaves as a write
        xfer(1, 1, 1, 1, 1, 8'h33, 1, wt, lat);
        chk("rw_busy_cycles", lat, 29);

        // reset in the middle of the enable pulse
        xfer(1, 1, 0, 1, 1, 8'h55, 0, wt, lat);
        idle_bus();
        n = 0;
        while (LCD_EN !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        chk("pulse_seen", LCD_EN, 1'b1);
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        chk("midpulse_rst_en", LCD_EN, 1'b0);
        chk("midpulse_rst_waitreq", waitrequest, 1'b1);
        wait_idle(n);
        chk("replay_wait_len", n > P_PWR, 1'b1);

        // 17-write burst: clear then 16 characters, master holds each write
        r0 = en_rises;
        xfer(1, 1, 0, 1, 0, 8'h01, 0, wt, lat);
        for (int i = 0; i < 16; i++) xfer(1, 1, 0, 1, 1, 8'h41 + 8'(i), 0, wt, lat);
        idle_bus();
        wait_idle(n);
        chk("burst_pulse_count", en_rises - r0, 17);

        // random traffic
        for (int i = 0; i < 80; i++) begin
            sel = $urandom_range(0, 9);
            op  = $urandom_range(0, 3);
            cs  = (sel != 0);
            w   = (op != 1);
            r   = (op == 1) || (op == 3);
            be  = ($urandom_range(0, 4) != 0);
            a   = 1'($urandom_range(0, 1));
            d   = ($urandom_range(0, 5) == 0) ? 8'($urandom_range(0, 3)) : 8'($urandom_range(0, 255));
            xfer(cs, w, r, be, a, d, 0, wt, lat);
            if ($urandom_range(0, 2) == 0) begin
                idle_bus();
                repeat ($urandom_range(0, 5)) @(negedge clk);
            end
        end
        idle_bus();
        wait_idle(n);
        repeat (5) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Hard stop if the run gets stuck.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, vectors=%0d miscompares=%0d", vectors, miscompares);
        $fatal(1, "time limit");
    end

endmodule
